pwm_ramp_sched: RTL and testbench

//  Ramp scheduler for a bank of N_CH PWM channels. Holds a current duty, a target and a step per channel.
//  One shared step engine visits every channel once per step tick and moves the current duty one step toward its target.

---
 rtl/pwm_ctrl_pkg.sv | 11 +
 rtl/pwm_tick_gen.sv | 23 ++
 rtl/pwm_ramp_sched.sv | 134 +++++++++++++
 tb/tb_pwm_ramp_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM control blocks.
package pwm_ctrl_pkg;

  typedef enum logic {IDLE, SCAN} ramp_state_t;

  // Full-scale duty for an r-bit PWM counter (100% duty).
  function automatic int unsigned duty_max(input int unsigned r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: tick is high for one cycle every tick_dvsr+1 cycles.
// It is high in the first cycle after reset.
module pwm_tick_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tick_dvsr,
  output logic        tick
);

  logic [31:0] q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else if (q == tick_dvsr)
      q <= '0;
    else
      q <= q + 32'd1;
  end

  assign tick = (q == '0);

endmodule

// File: rtl/pwm_ramp_sched.sv
// Ramp scheduler: one shared step engine walks every channel per step tick,
// moving each current duty one step toward its target.
module pwm_ramp_sched
  import pwm_ctrl_pkg::*;
#(
  parameter  int R    = 10,
  parameter  int N_CH = 4,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           tick_dvsr,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CW-1:0]         cmd_ch,
  input  logic [R:0]            cmd_target,
  input  logic [R:0]            cmd_step,
  output logic [N_CH*(R+1)-1:0] duty_flat,
  output logic [N_CH-1:0]       at_target,
  output logic                  overrun
);

  localparam int            DW   = R + 1;
  localparam logic [R:0]    DMAX = DW'(duty_max(R));
  localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

  logic        tick;
  ramp_state_t state;
  logic [CW-1:0] idx;
  logic        pending;
  logic        overrun_q;

  logic [R:0] cur  [N_CH];
  logic [R:0] tgt  [N_CH];
  logic [R:0] step [N_CH];

  logic [R+1:0] c_x, t_x, s_x, sum, gap, diff;
  logic [R:0]   next_cur;
  logic [R:0]   cmd_tgt_clamped;
  logic         ch_ok;
  logic         accept;

  pwm_tick_gen u_tick_gen (
    .clk       (clk),
    .reset     (reset),
    .tick_dvsr (tick_dvsr),
    .tick      (tick)
  );

  // Shared step datapath; one bit of headroom so neither direction can wrap.
  always_comb begin
    c_x      = {1'b0, cur[idx]};
    t_x      = {1'b0, tgt[idx]};
    s_x      = {1'b0, step[idx]};
    sum      = c_x + s_x;
    gap      = c_x - t_x;
    diff     = c_x - s_x;
    next_cur = cur[idx];
    if (c_x < t_x)
      next_cur = (sum > t_x) ? tgt[idx] : sum[R:0];
    else if (c_x > t_x)
      next_cur = (s_x >= gap) ? tgt[idx] : diff[R:0];
  end

  assign cmd_tgt_clamped = (cmd_target > DMAX) ? DMAX : cmd_target;
  assign ch_ok           = int'(cmd_ch) < N_CH;
  assign cmd_ready       = (state == IDLE) && !tick;
  assign accept          = cmd_valid && cmd_ready;
  assign overrun         = overrun_q;

  // Commands only land in IDLE without a tick, so they never race a channel update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      pending   <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cur[i]  <= '0;
        tgt[i]  <= '0;
        step[i] <= '0;
      end
    end else begin
      if (accept && ch_ok) begin
        tgt[cmd_ch]  <= cmd_tgt_clamped;
        step[cmd_ch] <= cmd_step;
        if (cmd_step == '0)
          cur[cmd_ch] <= cmd_tgt_clamped;
      end
      case (state)
        IDLE: begin
          if (tick) begin
            state <= SCAN;
            idx   <= '0;
          end
        end
        SCAN: begin
          cur[idx] <= next_cur;
          if (idx == LAST) begin
            idx <= '0;
            // A tick on the last channel with nothing pending simply starts the next scan.
            if (pending) begin
              pending <= 1'b0;
              if (tick)
                overrun_q <= 1'b1;
            end else if (!tick) begin
              state <= IDLE;
            end
          end else begin
            idx <= idx + 1'b1;
            if (tick) begin
              if (pending)
                overrun_q <= 1'b1;
              else
                pending <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    at_target = '0;
    for (int i = 0; i < N_CH; i++)
      at_target[i] = (cur[i] == tgt[i]);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_duty
    assign duty_flat[g*DW +: DW] = cur[g];
  end

endmodule

// File: tb/tb_pwm_ramp_sched.sv
// Directed bench for pwm_ramp_sched (N_CH=4) plus a 6-channel instance
// used for out-of-range channel commands.
module tb_pwm_ramp_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tick_dvsr;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_ch;
  logic [10:0] cmd_target, cmd_step;
  logic [43:0] duty_flat;
  logic [3:0]  at_target;
  logic        overrun;

  logic        b_cmd_valid, b_cmd_ready;
  logic [2:0]  b_cmd_ch;
  logic [10:0] b_cmd_target, b_cmd_step;
  logic [65:0] b_duty_flat;
  logic [5:0]  b_at_target;
  logic        b_overrun;

  int vectors = 0;
  int errors  = 0;
  int cyc;
  int acc_cnt = 0;

  always #5 clk = ~clk;

  pwm_ramp_sched #(.R(10), .N_CH(4)) dut (
    .clk(clk), .reset(reset), .tick_dvsr(tick_dvsr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
    .cmd_target(cmd_target), .cmd_step(cmd_step),
    .duty_flat(duty_flat), .at_target(at_target), .overrun(overrun)
  );

  pwm_ramp_sched #(.R(10), .N_CH(6)) dut6 (
    .clk(clk), .reset(reset), .tick_dvsr(tick_dvsr),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ch(b_cmd_ch),
    .cmd_target(b_cmd_target), .cmd_step(b_cmd_step),
    .duty_flat(b_duty_flat), .at_target(b_at_target), .overrun(b_overrun)
  );

  // cyc equals the current cycle index when sampled at a negedge (cycle 0 = first after release).
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [10:0] duty(input int i);
    return duty_flat[i*11 +: 11];
  endfunction

  function automatic logic [10:0] bduty(input int i);
    return b_duty_flat[i*11 +: 11];
  endfunction

  task automatic wait_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic do_reset(input logic [31:0] dvsr);
    reset       = 1'b1;
    tick_dvsr   = dvsr;
    cmd_valid   = 1'b0;
    cmd_ch      = '0;
    cmd_target  = '0;
    cmd_step    = '0;
    b_cmd_valid = 1'b0;
    b_cmd_ch    = '0;
    b_cmd_target = '0;
    b_cmd_step  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_cmd(input int ch, input int tgt, input int stp, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc    = -1;
    cmd_ch     = 2'(ch);
    cmd_target = 11'(tgt);
    cmd_step   = 11'(stp);
    cmd_valid  = 1'b1;
    for (int n = 0; n < 40 && !ok; n++) begin
      #1;
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    vectors++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL cmd_accept: got no handshake in 40 cycles, required one (ch %0d)", ch);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick_dvsr = 32'd0;
    cmd_valid = 1'b0;
    b_cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (duty_flat !== 44'd0) begin
      errors++; $display("[TB] FAIL reset_duty: got %h required 0", duty_flat);
    end
    vectors++;
    if (at_target !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_at_target: got %h required f", at_target);
    end
    vectors++;
    if (overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_overrun: got %b required 0", overrun);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) wait_cycle(c);
      #1;
      vectors++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL ready_tick_scan c%0d: got %b required 0", c, cmd_ready);
      end
    end
  endtask

  task automatic test_ramp_up();
    int acc;
    int chk_cyc [4] = '{13, 23, 33, 43};
    int chk_val [4] = '{30, 60, 90, 100};
    do_reset(32'd9);
    send_cmd(1, 100, 30, acc);
    vectors++;
    if (acc !== 5) begin
      errors++; $display("[TB] FAIL ramp_accept_cycle: got %0d required 5", acc);
    end
    wait_cycle(6);
    vectors++;
    if (at_target[1] !== 1'b0) begin
      errors++; $display("[TB] FAIL ramp_not_at_target: got %b required 0", at_target[1]);
    end
    wait_cycle(12);
    vectors++;
    if (duty(1) !== 11'd0) begin
      errors++; $display("[TB] FAIL ramp_latency: got %0d required 0", duty(1));
    end
    for (int k = 0; k < 4; k++) begin
      wait_cycle(chk_cyc[k]);
      vectors++;
      if (duty(1) !== 11'(chk_val[k])) begin
        errors++; $display("[TB] FAIL ramp_step%0d: got %0d required %0d", k, duty(1), chk_val[k]);
      end
    end
    vectors++;
    if (at_target !== 4'hF) begin
      errors++; $display("[TB] FAIL ramp_at_target: got %h required f", at_target);
    end
    vectors++;
    if ({duty(0), duty(2), duty(3)} !== 33'd0) begin
      errors++; $display("[TB] FAIL ramp_others: got %0d/%0d/%0d required 0/0/0", duty(0), duty(2), duty(3));
    end
  endtask

  task automatic test_clamp_down();
    int acc;
    do_reset(32'd9);
    send_cmd(2, 100, 0, acc);
    wait_cycle(6);
    vectors++;
    if (duty(2) !== 11'd100) begin
      errors++; $display("[TB] FAIL jump_100: got %0d required 100", duty(2));
    end
    send_cmd(2, 2000, 0, acc);
    wait_cycle(7);
    vectors++;
    if (duty(2) !== 11'd1024) begin
      errors++; $display("[TB] FAIL clamp_1024: got %0d required 1024", duty(2));
    end
    vectors++;
    if (at_target[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL clamp_at_target: got %b required 1", at_target[2]);
    end
    send_cmd(2, 0, 1000, acc);
    wait_cycle(8);
    vectors++;
    if (at_target[2] !== 1'b0) begin
      errors++; $display("[TB] FAIL down_not_at_target: got %b required 0", at_target[2]);
    end
    wait_cycle(13);
    vectors++;
    if (duty(2) !== 11'd1024) begin
      errors++; $display("[TB] FAIL down_latency: got %0d required 1024", duty(2));
    end
    wait_cycle(14);
    vectors++;
    if (duty(2) !== 11'd24) begin
      errors++; $display("[TB] FAIL down_24: got %0d required 24", duty(2));
    end
    wait_cycle(24);
    vectors++;
    if (duty(2) !== 11'd0) begin
      errors++; $display("[TB] FAIL down_floor: got %0d required 0", duty(2));
    end
    vectors++;
    if (at_target[2] !== 1'b1) begin
      errors++; $display("[TB] FAIL down_at_target: got %b required 1", at_target[2]);
    end
  endtask

  task automatic test_overrun();
    do_reset(32'd1);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) wait_cycle(c);
      #1;
      vectors++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL overrun_ready c%0d: got %b required 0", c, cmd_ready);
      end
      if (c == 4) begin
        vectors++;
        if (overrun !== 1'b0) begin
          errors++; $display("[TB] FAIL overrun_early: got %b required 0", overrun);
        end
      end
      if (c == 5) begin
        vectors++;
        if (overrun !== 1'b1) begin
          errors++; $display("[TB] FAIL overrun_set: got %b required 1", overrun);
        end
      end
    end
    wait_cycle(30);
    vectors++;
    if (overrun !== 1'b1) begin
      errors++; $display("[TB] FAIL overrun_sticky: got %b required 1", overrun);
    end
  endtask

  task automatic test_handshake();
    int acc;
    int base;
    do_reset(32'd9);
    base = acc_cnt;
    wait_cycle(10);
    send_cmd(0, 9, 0, acc);
    vectors++;
    if (acc !== 15) begin
      errors++; $display("[TB] FAIL hs_accept_cycle: got %0d required 15", acc);
    end
    wait_cycle(16);
    vectors++;
    if (acc_cnt - base !== 1) begin
      errors++; $display("[TB] FAIL hs_write_count: got %0d required 1", acc_cnt - base);
    end
    vectors++;
    if (duty(0) !== 11'd9) begin
      errors++; $display("[TB] FAIL hs_duty0: got %0d required 9", duty(0));
    end
    wait_cycle(17);
    b_cmd_valid = 1'b1; b_cmd_ch = 3'd5; b_cmd_target = 11'd33; b_cmd_step = 11'd0;
    wait_cycle(18);
    b_cmd_ch = 3'd6; b_cmd_target = 11'd44;
    #1;
    vectors++;
    if (b_cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL oor_ready: got %b required 1", b_cmd_ready);
    end
    wait_cycle(19);
    b_cmd_ch = 3'd7; b_cmd_target = 11'd55;
    wait_cycle(20);
    b_cmd_valid = 1'b0;
    vectors++;
    if (bduty(5) !== 11'd33) begin
      errors++; $display("[TB] FAIL oor_in_range: got %0d required 33", bduty(5));
    end
    vectors++;
    if (b_duty_flat[54:0] !== 55'd0) begin
      errors++; $display("[TB] FAIL oor_discard: got %h required 0", b_duty_flat[54:0]);
    end
    vectors++;
    if (b_at_target !== 6'h3F) begin
      errors++; $display("[TB] FAIL oor_at_target: got %h required 3f", b_at_target);
    end
  endtask

  task automatic test_reset_mid_scan();
    int acc;
    do_reset(32'd9);
    send_cmd(0, 200, 20, acc);
    wait_cycle(11);
    vectors++;
    if (duty(0) !== 11'd0) begin
      errors++; $display("[TB] FAIL mid_latency: got %0d required 0", duty(0));
    end
    wait_cycle(12);
    vectors++;
    if (duty(0) !== 11'd20) begin
      errors++; $display("[TB] FAIL mid_first_step: got %0d required 20", duty(0));
    end
    wait_cycle(22);
    vectors++;
    if (duty(0) !== 11'd40) begin
      errors++; $display("[TB] FAIL mid_second_step: got %0d required 40", duty(0));
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (duty_flat !== 44'd0 || at_target !== 4'hF || overrun !== 1'b0) begin
      errors++; $display("[TB] FAIL mid_reset: got duty %h at %h ovr %b required 0/f/0", duty_flat, at_target, overrun);
    end
    do_reset(32'd9);
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) wait_cycle(c);
      #1;
      vectors++;
      if (cmd_ready !== (c == 5)) begin
        errors++; $display("[TB] FAIL clean_scan_ready c%0d: got %b required %b", c, cmd_ready, c == 5);
      end
    end
    send_cmd(0, 30, 10, acc);
    wait_cycle(11);
    vectors++;
    if (duty(0) !== 11'd0) begin
      errors++; $display("[TB] FAIL clean_latency: got %0d required 0", duty(0));
    end
    wait_cycle(12);
    vectors++;
    if (duty(0) !== 11'd10) begin
      errors++; $display("[TB] FAIL clean_step: got %0d required 10", duty(0));
    end
  endtask

  initial begin
    reset = 1'b1;
    tick_dvsr = 32'd0;
    cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0; cmd_step = '0;
    b_cmd_valid = 1'b0; b_cmd_ch = '0; b_cmd_target = '0; b_cmd_step = '0;
    test_reset();
    test_ramp_up();
    test_clamp_down();
    test_overrun();
    test_handshake();
    test_reset_mid_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
